// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3 codes,
// FSM state encoding, the default timeout, and request classification helpers.
package load_store_unit_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic funct3_legal(input logic is_write, input logic [2:0] funct3);
        logic ok;
        if (is_write) begin
            ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: byte enables, store-data shifting and
// load-data extraction with sign/zero extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_result
);

    logic [1:0]  lane;
    logic [31:0] load_shifted;

    // Halfwords only honour addr[1] and words always sit in lane 0
    always_comb begin
        lane    = 2'b00;
        byte_en = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane    = offset;
                byte_en = 4'b0001 << offset;
            end
            2'b01: begin
                lane    = {offset[1], 1'b0};
                byte_en = 4'b0011 << {offset[1], 1'b0};
            end
            default: begin
                lane    = 2'b00;
                byte_en = 4'b1111;
            end
        endcase

        store_lanes  = store_data << {lane, 3'b000};
        load_shifted = load_word >> {lane, 3'b000};

        case (funct3)
            F3_LB:   load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
            F3_LH:   load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
            F3_LBU:  load_result = {24'h0, load_shifted[7:0]};
            F3_LHU:  load_result = {16'h0, load_shifted[15:0]};
            default: load_result = load_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with handshaked memory port and access timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e       state_q, state_d;
    logic             write_q, write_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       offset_q, offset_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [2:0]  align_funct3;
    logic [1:0]  align_offset;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;
    logic        req_bad;

    // The single aligner serves the incoming request in IDLE and the held one afterwards
    always_comb begin
        align_funct3 = funct3_q;
        align_offset = offset_q;
        if (state_q == ST_IDLE) begin
            align_funct3 = req_funct3;
            align_offset = req_addr[1:0];
        end
    end

    lsu_lane_align u_align (
        .funct3      (align_funct3),
        .offset      (align_offset),
        .store_data  (req_wdata),
        .load_word   (mem_rdata),
        .byte_en     (align_be),
        .store_lanes (align_wdata),
        .load_result (align_rdata)
    );

    always_comb begin
        req_bad = !funct3_legal(req_write, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = req_bad | addr_misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    offset_d = req_addr[1:0];
                    if (req_bad) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = align_be;
                        mem_wdata_d = align_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // An ack on the final counted cycle still completes cleanly
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (!write_q) begin
                        rdata_d = align_rdata;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    if (!write_q) begin
                        rdata_d = 32'h0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign busy      = !rst && (((state_q == ST_IDLE) && req_valid) || (state_q == ST_ACCESS));
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
